// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction fields and pipeline status in,
// forwarding selects, stage hold/flush controls and the stall counter out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ex_redirect;
  logic                  mem_busy;
  logic [1:0]            rd1_ctr;
  logic [1:0]            rd2_ctr;
  logic                  pc_hold;
  logic                  if_id_hold;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  freeze;
  logic [CNT_W-1:0]      load_use_cnt;

  // Core side: presents the decoded instruction and pipeline status.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_redirect, mem_busy,
    input  rd1_ctr, rd2_ctr, pc_hold, if_id_hold, if_id_flush,
           id_ex_bubble, freeze, load_use_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_redirect, mem_busy,
    output rd1_ctr, rd2_ctr, pc_hold, if_id_hold, if_id_flush,
           id_ex_bubble, freeze, load_use_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core. Shadows the EX/MEM/WB
// destination info to produce EX operand-forwarding selects, detects load-use
// hazards, and sequences stall / flush / freeze of the pipeline registers.
// Only the slot fields that feed a decision are stored: EX keeps its sources
// and load flag, MEM and WB only need to be recognised as producers.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  // p0 = EX slot, p1 = MEM slot, p2 = WB slot
  logic                  vld_p0, vld_p1, vld_p2;
  logic [REG_ADDR_W-1:0] rd_p0, rd_p1, rd_p2;
  logic                  rw_p0, rw_p1, rw_p2;
  logic                  mr_p0;
  logic [REG_ADDR_W-1:0] rs1_p0, rs2_p0;
  logic                  rs1_used_p0, rs2_used_p0;

  logic                  lu;
  logic                  lu_win;
  logic                  bubble;
  logic                  pc_hold, if_id_hold, if_id_flush, freeze;
  logic                  mem_wr, wb_wr;
  logic [CNT_W-1:0]      cnt;

  function automatic logic writer(input logic vld, input logic rw,
                                  input logic [REG_ADDR_W-1:0] rd);
    return vld & rw & (rd != '0);
  endfunction

  // Youngest producer wins: MEM result before WB result.
  function automatic logic [1:0] fwd_sel(input logic ex_vld, input logic src_used,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic m_wr, input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic w_wr, input logic [REG_ADDR_W-1:0] w_rd);
    if (ex_vld && src_used && m_wr && (m_rd == src)) return 2'b01;
    if (ex_vld && src_used && w_wr && (w_rd == src)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign mem_wr = writer(vld_p1, rw_p1, rd_p1);
  assign wb_wr  = writer(vld_p2, rw_p2, rd_p2);

  // A load in MEM still selects 01: the MEM-stage mux puts load data on that path.
  assign bus.rd1_ctr = fwd_sel(vld_p0, rs1_used_p0, rs1_p0, mem_wr, rd_p1, wb_wr, rd_p2);
  assign bus.rd2_ctr = fwd_sel(vld_p0, rs2_used_p0, rs2_p0, mem_wr, rd_p1, wb_wr, rd_p2);

  assign lu = bus.id_valid & vld_p0 & mr_p0 & rw_p0 & (rd_p0 != '0) &
              ((bus.id_rs1_used & (bus.id_rs1 == rd_p0)) |
               (bus.id_rs2_used & (bus.id_rs2 == rd_p0)));

  // Prioritised stage control: freeze, then redirect (kills the ID instruction), then load-use.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    bubble      = 1'b0;
    freeze      = 1'b0;
    lu_win      = 1'b0;
    if (rst_n) begin
      if (bus.mem_busy) begin
        freeze     = 1'b1;
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
      end else if (bus.ex_redirect) begin
        if_id_flush = 1'b1;
        bubble      = 1'b1;
      end else if (lu) begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        bubble     = 1'b1;
        lu_win     = 1'b1;
      end
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.if_id_hold   = if_id_hold;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.freeze       = freeze;
  assign bus.load_use_cnt = cnt;

  // ID -> EX -> MEM -> WB slot valids; everything holds while memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!bus.mem_busy) begin
      vld_p2 <= vld_p1;
      vld_p1 <= vld_p0;
      vld_p0 <= bus.id_valid & ~bubble;
    end
  end

  // Slot payload follows the valids; it is only ever read qualified by vld_pN.
  always_ff @(posedge clk) begin
    if (!bus.mem_busy) begin
      rd_p2       <= rd_p1;
      rw_p2       <= rw_p1;
      rd_p1       <= rd_p0;
      rw_p1       <= rw_p0;
      rd_p0       <= bus.id_rd;
      rw_p0       <= bus.id_reg_write;
      mr_p0       <= bus.id_mem_read;
      rs1_p0      <= bus.id_rs1;
      rs2_p0      <= bus.id_rs2;
      rs1_used_p0 <= bus.id_rs1_used;
      rs2_used_p0 <= bus.id_rs2_used;
    end
  end

  // Count load-use bubbles actually inserted, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (lu_win) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a table of per-cycle instruction vectors with the
// expected same-cycle outputs, plus hand sequences for counter saturation and
// asynchronous reset. Expected records go through a scoreboard queue.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;

  // Control bit order: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, freeze}
  localparam logic [4:0] C0    = 5'b00000;
  localparam logic [4:0] CBUSY = 5'b11001;
  localparam logic [4:0] CLU   = 5'b11010;
  localparam logic [4:0] CRED  = 5'b00110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();
  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic          vld;
    logic [AW-1:0] rd, rs1, rs2;
    logic          u1, u2, rw, mr, redir, busy;
    logic [1:0]    e1, e2;
    logic [4:0]    ectl;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[0:32];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic v, input int rd, input int rs1, input int rs2,
                              input logic u1, input logic u2, input logic rw, input logic mr,
                              input logic redir, input logic busy,
                              input logic [1:0] e1, input logic [1:0] e2,
                              input logic [4:0] ectl, input int ecnt);
    vec_t t;
    t.vld = v; t.rd = AW'(rd); t.rs1 = AW'(rs1); t.rs2 = AW'(rs2);
    t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr; t.redir = redir; t.busy = busy;
    t.e1 = e1; t.e2 = e2; t.ectl = ectl; t.ecnt = CW'(ecnt);
    return t;
  endfunction

  function automatic vec_t nop(input logic [1:0] e1, input logic [1:0] e2, input int ecnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e2, C0, ecnt);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid     = v.vld;
    bus.id_rd        = v.rd;
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rs1_used  = v.u1;
    bus.id_rs2_used  = v.u2;
    bus.id_reg_write = v.rw;
    bus.id_mem_read  = v.mr;
    bus.ex_redirect  = v.redir;
    bus.mem_busy     = v.busy;
    exp_q.push_back(v);
  endtask

  task automatic compare(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/rd1_ctr"}, 32'(bus.rd1_ctr), 32'(e.e1));
      chk({tag, "/rd2_ctr"}, 32'(bus.rd2_ctr), 32'(e.e2));
      chk({tag, "/ctl"}, 32'({bus.pc_hold, bus.if_id_hold, bus.if_id_flush,
                              bus.id_ex_bubble, bus.freeze}), 32'(e.ectl));
      chk({tag, "/load_use_cnt"}, 32'(bus.load_use_cnt), 32'(e.ecnt));
    end
  endtask

  // Drive one ID cycle between clock edges and check the combinational outputs.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;

    // ADD x5; SUB x5 back-to-back -> MEM forward; one gap -> WB forward
    tbl[0]  = mk(1, 5, 1, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[1]  = mk(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[2]  = nop(2'b01, 2'b00, 0);
    tbl[3]  = mk(1, 8, 3, 4, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[4]  = mk(1, 9, 10, 11, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[5]  = mk(1, 12, 8, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[6]  = nop(2'b10, 2'b00, 0);
    // MEM and WB both write x7, EX reads x7 on rs2 -> MEM wins
    tbl[7]  = mk(1, 7, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[8]  = mk(1, 7, 2, 2, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[9]  = mk(1, 13, 0, 7, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[10] = nop(2'b00, 2'b01, 0);
    // producer writing x0 is never forwarded
    tbl[11] = mk(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[12] = mk(1, 14, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[13] = nop(2'b00, 2'b00, 0);
    // LW x3; ADD ..,x3 -> one bubble, then consumer meets the load in WB
    tbl[14] = mk(1, 3, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, C0, 0);
    tbl[15] = mk(1, 15, 2, 3, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, CLU, 0);
    tbl[16] = mk(1, 15, 2, 3, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 1);
    tbl[17] = nop(2'b00, 2'b10, 1);
    // redirect together with load-use: flush wins, counter unchanged
    tbl[18] = mk(1, 4, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, C0, 1);
    tbl[19] = mk(1, 5, 4, 0, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00, CRED, 1);
    tbl[20] = nop(2'b00, 2'b00, 1);
    // mem_busy for 3 cycles while EX forwards from MEM
    tbl[21] = mk(1, 9, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 1);
    tbl[22] = mk(1, 10, 9, 4, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 1);
    tbl[23] = mk(1, 11, 10, 9, 1, 1, 1, 0, 0, 1, 2'b01, 2'b00, CBUSY, 1);
    tbl[24] = mk(1, 11, 10, 9, 1, 1, 1, 0, 0, 1, 2'b01, 2'b00, CBUSY, 1);
    tbl[25] = mk(1, 11, 10, 9, 1, 1, 1, 0, 0, 1, 2'b01, 2'b00, CBUSY, 1);
    tbl[26] = mk(1, 11, 10, 9, 1, 1, 1, 0, 0, 0, 2'b01, 2'b00, C0, 1);
    tbl[27] = nop(2'b01, 2'b10, 1);
    // mem_busy with load-use pending: freeze first, stall after release
    tbl[28] = mk(1, 6, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, C0, 1);
    tbl[29] = mk(1, 7, 6, 0, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00, CBUSY, 1);
    tbl[30] = mk(1, 7, 6, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, CLU, 1);
    tbl[31] = mk(1, 7, 6, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, C0, 2);
    tbl[32] = nop(2'b10, 2'b00, 2);

    drive(nop(2'b00, 2'b00, 0));
    #3;
    compare("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Saturation: 14 more stalls bring the 4-bit counter from 2 to 15 and past it
    exp_cnt = 2;
    for (int i = 0; i < 14; i++) begin
      step(mk(1, 3, 1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, C0, exp_cnt), $sformatf("sat_lw%0d", i));
      step(mk(1, 8, 2, 3, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, CLU, exp_cnt), $sformatf("sat_use%0d", i));
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    end
    step(nop(2'b00, 2'b00, exp_cnt), "sat_final");

    // Forwarding pending under freeze, then async reset mid-cycle
    step(mk(1, 20, 1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 15), "pre_rst_p");
    step(mk(1, 21, 20, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 15), "pre_rst_c");
    step(mk(1, 22, 21, 0, 1, 0, 1, 0, 1, 1, 2'b01, 2'b00, CBUSY, 15), "pre_rst_busy");
    #1 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(1, 22, 21, 0, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, C0, 0));
    compare("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(mk(1, 23, 20, 20, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, C0, 0), "post_rst_id");
    step(nop(2'b00, 2'b00, 0), "post_rst_ex");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
